// File: rtl/serial_adder.sv
// serial_adder: bit-serial N-bit adder, one full-adder cell plus a carry flip-flop, LSB first.
// Latency: N cycles from the accepting start edge to the done strobe; one result per N+2 cycles.
// Backpressure: none; start is only accepted in IDLE, and is ignored (not queued) in RUN and DONE.
//
// Ports:
//   clk, rst     rising-edge clock, asynchronous active-high reset
//   start        begin an addition (accepted only when idle)
//   a, b, cin    operands and carry-in, captured on the accepting edge
//   busy         high while the addition is in progress
//   done         one-cycle strobe: sum/cout were just updated
//   sum, cout    registered result a+b+cin (low N bits, carry-out)
module serial_adder #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         cout
);

  localparam int CW = $clog2(N + 1);
  // Only N-1 result bits need storing: on the completing edge the MSB is the
  // live full-adder output, so it goes straight into sum.
  localparam int RW = (N > 1) ? N - 1 : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state;
  logic [N-1:0]    ra;
  logic [N-1:0]    rb;
  logic [RW-1:0]   rs;
  logic            c;
  logic [CW-1:0]   cnt;

  // Full-adder cell on the current LSBs and the carry flop.
  logic            s;
  logic            c_nxt;
  logic [RW-1:0]   rs_shift;
  logic [N-1:0]    sum_nxt;

  assign s     = ra[0] ^ rb[0] ^ c;
  assign c_nxt = (ra[0] & rb[0]) | (ra[0] & c) | (rb[0] & c);

  generate
    if (N == 1) begin : g_one
      assign rs_shift = rs;
      assign sum_nxt  = s;
    end else if (N == 2) begin : g_two
      assign rs_shift = s;
      assign sum_nxt  = {s, rs};
    end else begin : g_wide
      assign rs_shift = {s, rs[RW-1:1]};
      assign sum_nxt  = {s, rs};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ra    <= '0;
      rb    <= '0;
      rs    <= '0;
      c     <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            ra    <= a;
            rb    <= b;
            c     <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          ra  <= ra >> 1;
          rb  <= rb >> 1;
          rs  <= rs_shift;
          c   <= c_nxt;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(N - 1)) begin
            sum   <= sum_nxt;
            cout  <= c_nxt;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          // Strobe lasts exactly one cycle; start is not looked at here.
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
